// File: rtl/ifu_pkg.sv
// Shared types and sizing for the instruction fetch unit.
// Buffer depth is set by IFU_PREFETCH_EN: defined gives two entries, undefined gives one.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_LO,
    S_HI,
    S_WR
  } state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetched instructions with a registered head.
// Its depth follows IFU_PREFETCH_EN through ifu_pkg::DEPTH.
module fetch_buffer
  import ifu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output entry_t           head
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           head_q, head_d;
  logic             valid_q, valid_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    // Head is precomputed from next-state so the output is a plain flop.
    valid_d = (count_d != '0);
    head_d  = valid_d ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head       = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches 16-bit instructions as two byte reads and hands them out over valid/ready.
// Define IFU_PREFETCH_EN to allow one instruction of prefetch while the head waits.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] Mem_Address,
  output logic        Mem_CS,
  output logic        Mem_WR,
  input  logic [7:0]  Mem_Data,
  output logic        IR_Valid,
  input  logic        IR_Ready,
  output logic [15:0] IROut,
  output logic [15:0] IR_PC,
  input  logic        Redirect,
  input  logic [15:0] Redirect_PC
);

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [7:0]       lo_q, lo_d;
  logic             push;
  logic             pop;
  logic             has_space;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  entry_t           head;
  entry_t           push_entry;

  assign has_space  = (count < CNT_W'(DEPTH));
  assign pop        = head_valid & IR_Ready;
  assign push_entry = '{pc: pc_q, instr: {Mem_Data, lo_q}};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lo_d    = lo_q;
    push    = 1'b0;
    case (state_q)
      S_LO: if (has_space) state_d = S_HI;
      S_HI: begin
        lo_d    = Mem_Data;
        state_d = S_WR;
      end
      S_WR: begin
        push    = 1'b1;
        pc_d    = pc_q + 16'd2;
        state_d = S_LO;
      end
      default: state_d = S_LO;
    endcase
    // A redirect drops the half-built word and any byte still returning.
    if (Redirect) begin
      push    = 1'b0;
      pc_d    = Redirect_PC;
      state_d = S_LO;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_LO;
      pc_q    <= RESET_PC;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
    end
  end

  // Chip select is forced inactive while reset is held.
  always_comb begin
    Mem_CS      = 1'b1;
    Mem_Address = pc_q;
    if (Reset) begin
      case (state_q)
        S_LO: Mem_CS = !has_space;
        S_HI: begin
          Mem_CS      = 1'b0;
          Mem_Address = pc_q + 16'd1;
        end
        default: Mem_CS = 1'b1;
      endcase
    end
  end

  assign Mem_WR = 1'b0;

  fetch_buffer u_buffer (
    .clk        (Clock),
    .rst_n      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (Redirect),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign IR_Valid = head_valid;
  assign IROut    = head.instr;
  assign IR_PC    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expectations follow IFU_PREFETCH_EN.
// A second instance with RESET_PC=FFFFh exercises address wraparound.
module tb_instr_fetch_unit;

`ifdef IFU_PREFETCH_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 1;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Mem_Address;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [7:0]  Mem_Data = 8'h00;
  logic        IR_Valid;
  logic        IR_Ready = 1'b0;
  logic [15:0] IROut;
  logic [15:0] IR_PC;
  logic        Redirect = 1'b0;
  logic [15:0] Redirect_PC = 16'h0000;

  logic        w_reset = 1'b0;
  logic [15:0] w_addr;
  logic        w_cs;
  logic        w_wr;
  logic [7:0]  w_data = 8'h00;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [15:0] w_irout;
  logic [15:0] w_irpc;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (!Mem_CS) Mem_Data <= mem[Mem_Address];
  always @(posedge Clock) if (!w_cs) w_data <= mem[w_addr];

  instr_fetch_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Mem_Address (Mem_Address),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .Mem_Data    (Mem_Data),
    .IR_Valid    (IR_Valid),
    .IR_Ready    (IR_Ready),
    .IROut       (IROut),
    .IR_PC       (IR_PC),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .Clock       (Clock),
    .Reset       (w_reset),
    .Mem_Address (w_addr),
    .Mem_CS      (w_cs),
    .Mem_WR      (w_wr),
    .Mem_Data    (w_data),
    .IR_Valid    (w_valid),
    .IR_Ready    (w_ready),
    .IROut       (w_irout),
    .IR_PC       (w_irpc),
    .Redirect    (1'b0),
    .Redirect_PC (16'h0000)
  );

  // Hold reset two cycles and release at a falling edge; that cycle is cycle 0.
  task automatic do_reset();
    Reset    = 1'b0;
    Redirect = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", IR_Valid); end
    checks++; if (IROut !== 16'h0000) begin failures++; $display("[TB] FAIL reset_irout got=%h exp=0000", IROut); end
    checks++; if (IR_PC !== 16'h0000) begin failures++; $display("[TB] FAIL reset_irpc got=%h exp=0000", IR_PC); end
    checks++; if (Mem_CS !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs got=%b exp=1", Mem_CS); end
    checks++; if (Mem_WR !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr got=%b exp=0", Mem_WR); end
    checks++; if (Mem_Address !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0000", Mem_Address); end
    checks++; if (w_addr !== 16'hFFFF || w_cs !== 1'b1 || w_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap_mem got=%h/%b/%b exp=ffff/1/0", w_addr, w_cs, w_wr); end
    Reset = 1'b1;
    #1;
    checks++; if (Mem_CS !== 1'b0 || Mem_Address !== 16'h0000) begin failures++; $display("[TB] FAIL cycle0_issue got=%b/%h exp=0/0000", Mem_CS, Mem_Address); end
  endtask

  task automatic test_first_fetch();
    int cyc;
    int exp_cyc;
    IR_Ready = 1'b1;
    do_reset();
    @(negedge Clock);
    checks++; if (Mem_CS !== 1'b0 || Mem_Address !== 16'h0001) begin failures++; $display("[TB] FAIL c1_hi_addr got=%b/%h exp=0/0001", Mem_CS, Mem_Address); end
    checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL c1_valid got=%b exp=0", IR_Valid); end
    @(negedge Clock);
    checks++; if (Mem_CS !== 1'b1) begin failures++; $display("[TB] FAIL c2_cs got=%b exp=1", Mem_CS); end
    @(negedge Clock);
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'h1234 || IR_PC !== 16'h0000) begin failures++; $display("[TB] FAIL first_word got=%b/%h/%h exp=1/1234/0000", IR_Valid, IROut, IR_PC); end
    cyc = 3;
    exp_cyc = (TB_DEPTH == 2) ? 6 : 7;
    do begin
      @(negedge Clock);
      cyc++;
    end while (IR_Valid !== 1'b1 && cyc < 20);
    checks++; if (cyc != exp_cyc) begin failures++; $display("[TB] FAIL second_word_cycle got=%0d exp=%0d", cyc, exp_cyc); end
    checks++; if (IROut !== 16'h1811 || IR_PC !== 16'h0002) begin failures++; $display("[TB] FAIL second_word got=%h/%h exp=1811/0002", IROut, IR_PC); end
    IR_Ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] exp_addr;
    IR_Ready = 1'b0;
    do_reset();
    repeat (3) @(negedge Clock);
    for (int c = 3; c < 8; c++) begin
      checks++; if (IR_Valid !== 1'b1 || IROut !== 16'h1234 || IR_PC !== 16'h0000) begin failures++; $display("[TB] FAIL stall_hold_c%0d got=%b/%h/%h exp=1/1234/0000", c, IR_Valid, IROut, IR_PC); end
      @(negedge Clock);
    end
    checks++; if (Mem_CS !== 1'b1 || IROut !== 16'h1234) begin failures++; $display("[TB] FAIL stall_full got=%b/%h exp=1/1234", Mem_CS, IROut); end
    IR_Ready = 1'b1;
    @(negedge Clock);
    IR_Ready = 1'b0;
    exp_addr = (TB_DEPTH == 2) ? 16'h0004 : 16'h0002;
    checks++; if (Mem_CS !== 1'b0 || Mem_Address !== exp_addr) begin failures++; $display("[TB] FAIL stall_resume got=%b/%h exp=0/%h", Mem_CS, Mem_Address, exp_addr); end
`ifdef IFU_PREFETCH_EN
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'h1811 || IR_PC !== 16'h0002) begin failures++; $display("[TB] FAIL stall_next_head got=%b/%h/%h exp=1/1811/0002", IR_Valid, IROut, IR_PC); end
`else
    checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_empty got=%b exp=0", IR_Valid); end
`endif
  endtask

  task automatic test_redirect_hi();
    IR_Ready = 1'b0;
    do_reset();
    repeat (4) @(negedge Clock);
    Redirect    = 1'b1;
    Redirect_PC = 16'h0100;
    @(negedge Clock);
    Redirect = 1'b0;
    checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL redir_flush got=%b exp=0", IR_Valid); end
    checks++; if (Mem_CS !== 1'b0 || Mem_Address !== 16'h0100) begin failures++; $display("[TB] FAIL redir_issue got=%b/%h exp=0/0100", Mem_CS, Mem_Address); end
    @(negedge Clock);
    checks++; if (IR_Valid !== 1'b0 || Mem_Address !== 16'h0101) begin failures++; $display("[TB] FAIL redir_hi got=%b/%h exp=0/0101", IR_Valid, Mem_Address); end
    @(negedge Clock);
    checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL redir_r3_valid got=%b exp=0", IR_Valid); end
    @(negedge Clock);
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'hBEEF || IR_PC !== 16'h0100) begin failures++; $display("[TB] FAIL redir_word got=%b/%h/%h exp=1/beef/0100", IR_Valid, IROut, IR_PC); end
  endtask

  task automatic test_redirect_handshake();
    IR_Ready = 1'b0;
    do_reset();
    repeat (7) @(negedge Clock);
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'h1234) begin failures++; $display("[TB] FAIL rh_head got=%b/%h exp=1/1234", IR_Valid, IROut); end
    IR_Ready    = 1'b1;
    Redirect    = 1'b1;
    Redirect_PC = 16'h0200;
    @(negedge Clock);
    Redirect = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL rh_gap_r%0d got=%b/%h exp=0", c, IR_Valid, IROut); end
      @(negedge Clock);
    end
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'hF00D || IR_PC !== 16'h0200) begin failures++; $display("[TB] FAIL rh_word got=%b/%h/%h exp=1/f00d/0200", IR_Valid, IROut, IR_PC); end
    IR_Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int wr_cyc;
    IR_Ready = 1'b1;
    do_reset();
    wr_cyc = (TB_DEPTH == 2) ? 5 : 6;
    repeat (wr_cyc) @(negedge Clock);
    checks++; if (Mem_CS !== 1'b1 || IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_wr_state got=%b/%b exp=1/0", Mem_CS, IR_Valid); end
    Reset = 1'b0;
    #1;
    checks++; if (IROut !== 16'h0000 || IR_PC !== 16'h0000 || IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_out got=%b/%h/%h exp=0/0000/0000", IR_Valid, IROut, IR_PC); end
    checks++; if (Mem_CS !== 1'b1 || Mem_Address !== 16'h0000) begin failures++; $display("[TB] FAIL mid_reset_mem got=%b/%h exp=1/0000", Mem_CS, Mem_Address); end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      checks++; if (IR_Valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_partial got=%b/%h exp=0", IR_Valid, IROut); end
    end
    @(negedge Clock);
    checks++; if (IR_Valid !== 1'b1 || IROut !== 16'h1234 || IR_PC !== 16'h0000) begin failures++; $display("[TB] FAIL mid_refetch got=%b/%h/%h exp=1/1234/0000", IR_Valid, IROut, IR_PC); end
    IR_Ready = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    int exp_cyc;
    mem[16'h0000] = 8'hAB;
    w_ready = 1'b1;
    @(negedge Clock);
    w_reset = 1'b1;
    #1;
    checks++; if (w_cs !== 1'b0 || w_addr !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_c0 got=%b/%h exp=0/ffff", w_cs, w_addr); end
    @(negedge Clock);
    checks++; if (w_cs !== 1'b0 || w_addr !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_hi_addr got=%b/%h exp=0/0000", w_cs, w_addr); end
    repeat (2) @(negedge Clock);
    checks++; if (w_valid !== 1'b1 || w_irout !== 16'hABCD || w_irpc !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_word got=%b/%h/%h exp=1/abcd/ffff", w_valid, w_irout, w_irpc); end
    cyc = 3;
    exp_cyc = (TB_DEPTH == 2) ? 6 : 7;
    do begin
      @(negedge Clock);
      cyc++;
    end while (w_valid !== 1'b1 && cyc < 20);
    checks++; if (cyc != exp_cyc || w_irpc !== 16'h0001 || w_irout !== 16'h1112) begin failures++; $display("[TB] FAIL wrap_next got=c%0d/%h/%h exp=c%0d/0001/1112", cyc, w_irpc, w_irout, exp_cyc); end
    w_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0000] = 8'h34;
    mem[16'h0001] = 8'h12;
    mem[16'h0100] = 8'hEF;
    mem[16'h0101] = 8'hBE;
    mem[16'h0200] = 8'h0D;
    mem[16'h0201] = 8'hF0;
    mem[16'hFFFF] = 8'hCD;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_hi();
    test_redirect_handshake();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
